// File: rtl/preif_stage.sv
// Pre-fetch stage: owns the fetch PC, issues instruction-RAM requests, applies redirects and
// drops data beats of cancelled fetches. Optional misaligned-PC flagging under PREIF_ADEF_EN.
module preif_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000,
  parameter int          CNT_W    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_allowin_i,
  output logic        preif_to_if_valid_o,
  output logic [31:0] pc_o,
  output logic        adef_o,
  output logic        inst_ram_req_o,
  output logic [31:0] inst_ram_addr_o,
  input  logic        inst_ram_addr_ok_i,
  input  logic        inst_ram_data_ok_i,
  output logic        inst_data_ok_o,
  input  logic        excep_flush_i,
  input  logic [31:0] excep_pc_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t           state;
  logic [31:0]      pc_r, redir_pc;
  logic             redir_v;
  logic [CNT_W-1:0] outst_cnt, cancel_cnt, outst_nxt;
  logic             redirect_now, mis, in_req, acc, cancel_evt;
  logic [31:0]      redir_tgt;

`ifdef PREIF_ADEF_EN
  assign mis = pc_r[1:0] != 2'b00;
`else
  assign mis = 1'b0;
`endif

  assign redirect_now = excep_flush_i | br_taken_i;
  assign redir_tgt    = excep_flush_i ? excep_pc_i : br_target_i;
  assign in_req       = state == S_REQ;
  assign acc          = inst_ram_req_o & inst_ram_addr_ok_i;

  assign adef_o              = mis;
  assign pc_o                = pc_r;
  assign inst_ram_addr_o     = pc_r;
  assign inst_ram_req_o      = in_req & ~mis;
  assign preif_to_if_valid_o = ~redirect_now &
                               ((state == S_WAIT) | (in_req & (acc | mis) & ~redir_v));
  assign inst_data_ok_o      = inst_ram_data_ok_i & (cancel_cnt == '0);

  assign outst_nxt  = outst_cnt + CNT_W'(acc) - CNT_W'(inst_ram_data_ok_i);
  // Every beat still owed at a redirect belongs to a dead fetch, including a pending
  // request whose addr_ok arrives after the redirect was latched.
  assign cancel_evt = redirect_now | (redir_v & acc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc_r       <= RESET_PC;
      redir_v    <= 1'b0;
      redir_pc   <= '0;
      outst_cnt  <= '0;
      cancel_cnt <= '0;
    end else begin
      outst_cnt <= outst_nxt;
      if (cancel_evt)
        cancel_cnt <= outst_nxt;
      else if (inst_ram_data_ok_i && cancel_cnt != '0)
        cancel_cnt <= cancel_cnt - 1'b1;

      case (state)
        S_IDLE, S_WAIT: begin
          if (redirect_now) begin
            pc_r  <= redir_tgt;
            state <= S_REQ;
          end else if (state == S_IDLE) begin
            state <= S_REQ;
          end else if (if_allowin_i) begin
            pc_r  <= pc_r + 32'd4;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (acc | mis) begin
            redir_v <= 1'b0;
            if (redirect_now)
              pc_r <= redir_tgt;
            else if (redir_v)
              pc_r <= redir_pc;
            else if (if_allowin_i) begin
              if (!mis) pc_r <= pc_r + 32'd4;
            end else if (!mis)
              state <= S_WAIT;
          end else if (redirect_now) begin
            // address must stay stable until addr_ok; remember where to go afterwards
            redir_v  <= 1'b1;
            redir_pc <= redir_tgt;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  a_outst_ovf: assert property (@(posedge clk) disable iff (!rst_n)
    !(acc && !inst_ram_data_ok_i && (&outst_cnt)));
  a_outst_unf: assert property (@(posedge clk) disable iff (!rst_n)
    !(inst_ram_data_ok_i && !acc && outst_cnt == '0));
endmodule

// File: tb/tb_preif_stage.sv
// Directed bench for preif_stage: reset, streaming, IF backpressure, redirects and beat cancel.
module tb_preif_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        allowin, aok, dok, fl, br;
  logic [31:0] fpc, btgt;
  logic        vld, adef, req, dok_o;
  logic [31:0] pc, addr;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  preif_stage dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .if_allowin_i        (allowin),
    .preif_to_if_valid_o (vld),
    .pc_o                (pc),
    .adef_o              (adef),
    .inst_ram_req_o      (req),
    .inst_ram_addr_o     (addr),
    .inst_ram_addr_ok_i  (aok),
    .inst_ram_data_ok_i  (dok),
    .inst_data_ok_o      (dok_o),
    .excep_flush_i       (fl),
    .excep_pc_i          (fpc),
    .br_taken_i          (br),
    .br_target_i         (btgt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic drv(input logic al, input logic ao, input logic d, input logic f, input logic b);
    allowin = al; aok = ao; dok = d; fl = f; br = b;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; allowin = 1'b1; aok = 1'b1; dok = 1'b0; fl = 1'b0; br = 1'b0;
    fpc = '0; btgt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc",   pc,    32'h1c00_0000);
    chk("rst_addr", addr,  32'h1c00_0000);
    chk("rst_req",  req,   0);
    chk("rst_vld",  vld,   0);
    chk("rst_dok",  dok_o, 0);
    chk("rst_adef", adef,  0);
    rst_n = 1'b1; #1;
    chk("idle_req", req, 0);

    // back-to-back fetch at one PC per cycle
    nxt; drv(1,1,0,0,0);
    chk("seq0_addr", addr, 32'h1c00_0000); chk("seq0_req", req, 1); chk("seq0_vld", vld, 1);
    nxt; drv(1,1,0,0,0);
    chk("seq1_addr", addr, 32'h1c00_0004);
    nxt; drv(1,1,1,0,0);
    chk("seq2_addr", addr, 32'h1c00_0008); chk("seq2_dok", dok_o, 1);

    // reset in the middle of traffic
    nxt; rst_n = 1'b0; drv(0,1,0,0,0);
    nxt;
    chk("mrst_pc", pc, 32'h1c00_0000); chk("mrst_req", req, 0);
    rst_n = 1'b1; #1;

    // IF backpressure holds the accepted PC
    nxt; drv(0,1,0,0,0);
    chk("bp_req0", req, 1); chk("bp_vld0", vld, 1); chk("bp_addr0", addr, 32'h1c00_0000);
    for (int i = 0; i < 3; i++) begin
      nxt; drv(0,1,0,0,0);
      chk("bp_pc", pc, 32'h1c00_0000); chk("bp_vld", vld, 1); chk("bp_req", req, 0);
    end
    nxt; drv(1,1,0,0,0);
    chk("bp_rel_vld", vld, 1); chk("bp_rel_pc", pc, 32'h1c00_0000);
    nxt; drv(1,1,1,0,0);
    chk("bp_adv_pc", pc, 32'h1c00_0004); chk("bp_adv_req", req, 1); chk("bp_adv_dok", dok_o, 1);

    // branch while the request waits for addr_ok
    nxt; btgt = 32'h1c00_0100; drv(1,0,1,0,1);
    chk("br_vld", vld, 0); chk("br_addr", addr, 32'h1c00_0008);
    chk("br_req", req, 1); chk("br_dok", dok_o, 1);
    for (int i = 0; i < 2; i++) begin
      nxt; drv(1,0,0,0,0);
      chk("br_hold_addr", addr, 32'h1c00_0008); chk("br_hold_vld", vld, 0);
    end
    nxt; drv(1,1,0,0,0);
    chk("br_aok_vld", vld, 0); chk("br_aok_addr", addr, 32'h1c00_0008);
    nxt; drv(1,0,1,0,0);
    chk("br_tgt_addr", addr, 32'h1c00_0100); chk("br_tgt_req", req, 1); chk("br_drop", dok_o, 0);

    // flush and branch together with two outstanding
    nxt; drv(1,1,0,0,0);
    chk("f_a0_vld", vld, 1); chk("f_a0_addr", addr, 32'h1c00_0100);
    nxt; drv(0,1,0,0,0);
    chk("f_a1_addr", addr, 32'h1c00_0104);
    nxt; fpc = 32'h1c00_f000; btgt = 32'h1c00_0100; drv(1,0,0,1,1);
    chk("fl_vld", vld, 0);
    nxt; drv(0,0,1,0,0);
    chk("fl_addr", addr, 32'h1c00_f000); chk("fl_drop0", dok_o, 0);
    nxt; drv(1,1,1,0,0);
    chk("fl_drop1", dok_o, 0);
    nxt; drv(1,0,1,0,0);
    chk("fl_fwd", dok_o, 1); chk("fl_nxt_addr", addr, 32'h1c00_f004);

    // data_ok in the same cycle as the flush
    nxt; drv(1,1,0,0,0);
    nxt; drv(0,1,0,0,0);
    chk("sc_addr", addr, 32'h1c00_f008);
    nxt; fpc = 32'h1c00_0200; drv(1,0,1,1,0);
    chk("sc_dok", dok_o, 1); chk("sc_vld", vld, 0);
    nxt; drv(1,0,1,0,0);
    chk("sc_drop", dok_o, 0); chk("sc_tgt", addr, 32'h1c00_0200);
    nxt; drv(1,1,0,0,0);
    nxt; drv(1,0,1,0,0);
    chk("sc_fwd", dok_o, 1);

`ifdef PREIF_ADEF_EN
    // misaligned target: no request, presented to IF until redirected
    nxt; fpc = 32'h1c00_0002; drv(1,1,0,1,0);
    chk("ad_fl_vld", vld, 0);
    nxt; drv(1,1,1,0,0);
    chk("ad_adef", adef, 1); chk("ad_req", req, 0); chk("ad_vld", vld, 1);
    chk("ad_pc", pc, 32'h1c00_0002); chk("ad_drop", dok_o, 0);
    nxt; btgt = 32'h1c00_0010; drv(1,0,0,0,1);
    chk("ad_hold_pc", pc, 32'h1c00_0002); chk("ad_br_vld", vld, 0);
    nxt; drv(1,1,0,0,0);
    chk("ad_res_adef", adef, 0); chk("ad_res_req", req, 1); chk("ad_res_addr", addr, 32'h1c00_0010);
`endif

    nxt; drv(0,0,0,0,0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
